// File: rtl/gol_ram_if.sv
// Address/data bundle for the Game-of-Life cell-state RAM.
// The generation and display engines drive this bus as master. The RAM is the slave.
interface gol_ram_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 4
);
  logic [ADDR_W-1:0] addr;
  logic              we;
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] dout;

  modport master (output addr, output we, output din, input dout);
  modport slave  (input addr, input we, input din, output dout);
endinterface

// File: rtl/gol_ram.sv
// Single-port cell-state RAM. Reads are registered with a latency of 1 cycle.
// Writes are write-through: dout shows the word just written.
module gol_ram #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  gol_ram_if.slave    bus
);
  localparam int DEPTH = 1 << ADDR_W;

  // The array starts at zero. It is never reset, which keeps it mappable to block RAM.
  logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

  logic [DATA_W-1:0] dout_d, dout_q;

  always_ff @(posedge clk) begin
    if (bus.we && !rst)
      mem[bus.addr] <= bus.din;
  end

  always_comb begin
    dout_d = mem[bus.addr];
    if (bus.we)
      dout_d = bus.din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) dout_q <= '0;
    else     dout_q <= dout_d;
  end

  assign bus.dout = dout_q;
endmodule

// File: tb/tb_gol_ram.sv
// Bench for gol_ram. Directed cases are followed by a random phase.
// All cases are checked against a flat-array model of the RAM.
module tb_gol_ram;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gol_ram_if #(.ADDR_W(16), .DATA_W(4)) bus ();
  gol_ram #(.ADDR_W(16), .DATA_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [3:0] model [65536];
  logic [3:0] exp_dout;
  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, advance one edge, update the model, check dout.
  task automatic step(input logic r, input logic w, input logic [15:0] a,
                      input logic [3:0] d, input string tag);
    rst = r; bus.we = w; bus.addr = a; bus.din = d;
    @(posedge clk); #1;
    if (r)      exp_dout = 4'h0;
    else if (w) begin model[a] = d; exp_dout = d; end
    else        exp_dout = model[a];
    chk(tag, bus.dout, exp_dout);
  endtask

  initial begin
    logic [15:0] pool [5];
    logic [15:0] ra;
    logic        rw, rr;
    for (int i = 0; i < 65536; i++) model[i] = 4'h0;
    bus.we = 1'b0; bus.addr = '0; bus.din = '0;

    // A write issued under reset must be suppressed.
    step(1, 1, 16'h0005, 4'hA, "rst_hold0");
    step(1, 1, 16'h0005, 4'hA, "rst_hold1");
    step(0, 0, 16'h0005, 4'h0, "rst_write_suppressed");

    // Writes on consecutive cycles, then read each address back.
    step(0, 1, 16'h0000, 4'h1, "wr_0000");
    step(0, 1, 16'h0001, 4'h2, "wr_0001");
    step(0, 1, 16'h0100, 4'h3, "wr_0100");
    step(0, 1, 16'hFFFF, 4'h7, "wr_ffff");
    step(0, 0, 16'h0000, 4'h0, "rd_0000");
    step(0, 0, 16'h0001, 4'h0, "rd_0001");
    step(0, 0, 16'h0100, 4'h0, "rd_0100");
    step(0, 0, 16'hFFFF, 4'h0, "rd_ffff");

    // Latency: the previous data holds until the next edge.
    bus.addr = 16'h1234;
    #3 chk("lat_hold_before_edge", bus.dout, 4'h7);
    step(0, 0, 16'h1234, 4'h0, "lat_unwritten_zero");

    // Write-through, then read back on the following cycle.
    step(0, 1, 16'h0042, 4'hC, "wfirst_wr");
    step(0, 0, 16'h0042, 4'h0, "wfirst_rd");

    // The two addresses must stay distinct, and an overwrite must take effect.
    step(0, 1, 16'h0001, 4'h5, "alias_wr_0001");
    step(0, 1, 16'h0100, 4'h9, "alias_wr_0100");
    step(0, 0, 16'h0001, 4'h0, "alias_rd_0001");
    step(0, 0, 16'h0100, 4'h0, "alias_rd_0100");
    step(0, 1, 16'h0001, 4'hF, "ovw_wr_0001");
    step(0, 0, 16'h0001, 4'h0, "ovw_rd_0001");

    // Reset asserted between edges clears dout at once and leaves contents intact.
    step(0, 0, 16'h0100, 4'h0, "midrst_stream");
    #2 rst = 1'b1;
    #1 chk("midrst_async_clear", bus.dout, 4'h0);
    step(1, 0, 16'h0042, 4'h0, "midrst_held");
    step(0, 0, 16'hFFFF, 4'h0, "midrst_preserved");

    // Random phase. Addresses are drawn mostly from a small pool so that reads hit written words.
    pool[0] = 16'h0000; pool[1] = 16'hFFFF; pool[2] = 16'h0001;
    pool[3] = 16'h0100; pool[4] = 16'h0042;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) ra = 16'($urandom);
      else                           ra = pool[$urandom_range(0, 4)];
      rw = 1'($urandom_range(0, 1));
      rr = ($urandom_range(0, 31) == 0);
      step(rr, rw, ra, 4'($urandom), "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
